password_vault: RTL and testbench

PASSWORD_VAULT -- requirements
Module: password_vault

---
 rtl/pv_pkg.sv | 17 +
 rtl/pv_entry_array.sv | 61 ++++++
 rtl/password_vault.sv | 129 ++++++++++++
 tb/tb_password_vault.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pv_pkg.sv
// Shared definitions for the password vault: FSM state encoding and the
// default parameter values used by the top and its entry array.
package pv_pkg;

  localparam int DATA_W_DEF      = 8;
  localparam int DEPTH_DEF       = 16;
  localparam int ADDR_W_DEF      = 4;
  localparam int MAX_FAILS_DEF   = 3;
  localparam int LOCK_CYCLES_DEF = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RESP = 2'd1,
    LOCK = 2'd2
  } state_t;

endpackage

// File: rtl/pv_entry_array.sv
// Password entry storage: DEPTH entries of DATA_W bits plus a valid bit,
// with write/erase ports and one internal combinational read port.
module pv_entry_array
  import pv_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_allow,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              clr_en,
  input  logic [ADDR_W-1:0] clr_addr,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid
);

  logic [DATA_W-1:0] data_q [DEPTH];
  logic [DEPTH-1:0]  valid_q;

  // Update entries; addresses >= DEPTH never match an index and are dropped.
  // A write and an erase to the same entry in one cycle resolve to the write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the entries sit in flops with async reset on purpose: secrets
      // must be wiped on reset, so this array cannot be mapped to a RAM macro.
      for (int i = 0; i < DEPTH; i++) data_q[i] <= '0;
      valid_q <= '0;
    end else if (wr_allow) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (wr_en && wr_addr == ADDR_W'(i)) begin
          data_q[i]  <= wr_data;
          valid_q[i] <= 1'b1;
        end else if (clr_en && clr_addr == ADDR_W'(i)) begin
          data_q[i]  <= '0;
          valid_q[i] <= 1'b0;
        end
      end
    end
  end

  // Read mux; an out-of-range address reads back as an empty entry.
  always_comb begin
    // NOTE: defaults first so every path assigns the outputs and no latch
    // is inferred when no index matches.
    rd_data  = '0;
    rd_valid = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (rd_addr == ADDR_W'(i)) begin
        rd_data  = data_q[i];
        rd_valid = valid_q[i];
      end
    end
  end

endmodule

// File: rtl/password_vault.sv
// Password vault: stores secrets, answers check requests with a match bit
// only, counts consecutive failures and locks out after too many of them.
module password_vault
  import pv_pkg::*;
#(
  parameter int DATA_W      = DATA_W_DEF,
  parameter int DEPTH       = DEPTH_DEF,
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int MAX_FAILS   = MAX_FAILS_DEF,
  parameter int LOCK_CYCLES = LOCK_CYCLES_DEF
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             wr_en,
  input  logic [ADDR_W-1:0]                wr_addr,
  input  logic [DATA_W-1:0]                wr_data,
  input  logic                             clr_en,
  input  logic [ADDR_W-1:0]                clr_addr,
  input  logic                             chk_valid,
  output logic                             chk_ready,
  input  logic [ADDR_W-1:0]                chk_addr,
  input  logic [DATA_W-1:0]                chk_data,
  output logic                             res_valid,
  output logic                             res_match,
  output logic                             locked,
  output logic [$clog2(MAX_FAILS+1)-1:0]   fail_cnt
);

  localparam int FCNT_W = $clog2(MAX_FAILS + 1);
  localparam int LCNT_W = $clog2(LOCK_CYCLES + 1);
  localparam logic [FCNT_W-1:0] FAIL_MAX  = FCNT_W'(MAX_FAILS);
  localparam logic [LCNT_W-1:0] LOCK_LOAD = LCNT_W'(LOCK_CYCLES);
  localparam logic [ADDR_W:0]   DEPTH_V   = (ADDR_W + 1)'(DEPTH);

  state_t              state_q, state_d;
  logic [FCNT_W-1:0]   fail_cnt_q, fail_cnt_d;
  logic [LCNT_W-1:0]   lock_cnt_q, lock_cnt_d;
  logic                match_q, match_d;
  logic [DATA_W-1:0]   rd_data;
  logic                rd_valid;
  logic                in_range;
  logic                cmp_match;
  logic                accept;

  pv_entry_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_entries (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_allow (state_q != LOCK),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .clr_en   (clr_en),
    .clr_addr (clr_addr),
    .rd_addr  (chk_addr),
    .rd_data  (rd_data),
    .rd_valid (rd_valid)
  );

  // The comparison sees the entry as it is before this edge's write/erase.
  assign in_range  = ({1'b0, chk_addr} < DEPTH_V);
  assign cmp_match = in_range && rd_valid && (rd_data == chk_data);

  // Ready is gated by rst_n so it reads low while reset is held and rises
  // in the very first cycle after release.
  assign chk_ready = (state_q == IDLE) && rst_n;
  assign accept    = chk_valid && chk_ready;
  assign res_valid = (state_q == RESP);
  assign res_match = res_valid && match_q;
  assign locked    = (state_q == LOCK);
  assign fail_cnt  = fail_cnt_q;

  // State, failure counter, lockout counter and registered result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples pre-edge values regardless of block ordering.
      state_q    <= IDLE;
      fail_cnt_q <= '0;
      lock_cnt_q <= '0;
      match_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      fail_cnt_q <= fail_cnt_d;
      lock_cnt_q <= lock_cnt_d;
      match_q    <= match_d;
    end
  end

  // Next-state logic: accept in IDLE, present in RESP, count down in LOCK.
  always_comb begin
    state_d    = state_q;
    fail_cnt_d = fail_cnt_q;
    lock_cnt_d = lock_cnt_q;
    match_d    = match_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = RESP;
          match_d = cmp_match;
          if (cmp_match)               fail_cnt_d = '0;
          else if (fail_cnt_q != FAIL_MAX) fail_cnt_d = fail_cnt_q + 1'b1;
        end
      end
      RESP: begin
        if (fail_cnt_q == FAIL_MAX) begin
          state_d    = LOCK;
          lock_cnt_d = LOCK_LOAD;
        end else begin
          state_d = IDLE;
        end
      end
      LOCK: begin
        if (lock_cnt_q <= LCNT_W'(1)) begin
          state_d    = IDLE;
          lock_cnt_d = '0;
          fail_cnt_d = '0;
        end else begin
          lock_cnt_d = lock_cnt_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_password_vault.sv
// Scoreboard bench for password_vault: directed scenarios plus random
// traffic, all predicted by a behavioural model of the vault.
module tb_password_vault;

  localparam int DATA_W      = 8;
  localparam int DEPTH       = 10;
  localparam int ADDR_W      = 4;
  localparam int MAX_FAILS   = 3;
  localparam int LOCK_CYCLES = 16;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              wr_en, clr_en, chk_valid;
  logic [ADDR_W-1:0] wr_addr, clr_addr, chk_addr;
  logic [DATA_W-1:0] wr_data, chk_data;
  logic              chk_ready, res_valid, res_match, locked;
  logic [1:0]        fail_cnt;

  password_vault #(
    .DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W),
    .MAX_FAILS(MAX_FAILS), .LOCK_CYCLES(LOCK_CYCLES)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .clr_en(clr_en), .clr_addr(clr_addr),
    .chk_valid(chk_valid), .chk_ready(chk_ready),
    .chk_addr(chk_addr), .chk_data(chk_data),
    .res_valid(res_valid), .res_match(res_match),
    .locked(locked), .fail_cnt(fail_cnt)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int leak     = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(string name, int actual, int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct { bit match; int fcnt; int due; } exp_t;
  exp_t sb[$];

  bit [7:0] m_data [16];
  bit       m_vld  [16];
  int       m_fcnt;
  int       lock_lo, lock_hi, resp_cyc;

  function automatic bit model_locked(int x);
    return (x >= lock_lo) && (x <= lock_hi);
  endfunction

  function automatic bit model_ready(int x);
    return !model_locked(x) && (x != resp_cyc);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin m_data[i] = 8'h00; m_vld[i] = 1'b0; end
    m_fcnt = 0; lock_lo = 1; lock_hi = 0; resp_cyc = -5;
  endtask

  task automatic model_write(int a, bit [7:0] d, int x);
    if (!model_locked(x) && a < DEPTH) begin m_data[a] = d; m_vld[a] = 1'b1; end
  endtask

  task automatic model_erase(int a, int x);
    if (!model_locked(x) && a < DEPTH) begin m_data[a] = 8'h00; m_vld[a] = 1'b0; end
  endtask

  // Acceptance during cycle x: result shows in x+1, lockout spans the
  // following LOCK_CYCLES cycles after a failure count hits the limit.
  task automatic model_accept(int a, bit [7:0] d, int x);
    exp_t e;
    e.match = (a < DEPTH) && m_vld[a] && (m_data[a] == d);
    if (e.match) m_fcnt = 0;
    else if (m_fcnt < MAX_FAILS) m_fcnt++;
    e.fcnt = m_fcnt;
    e.due  = x + 1;
    sb.push_back(e);
    resp_cyc = x + 1;
    if (m_fcnt == MAX_FAILS) begin
      lock_lo = x + 2;
      lock_hi = x + 1 + LOCK_CYCLES;
      m_fcnt  = 0;
    end
  endtask

  // ---------------- monitor ----------------
  exp_t got;
  always @(negedge clk) begin
    if (rst_n) begin
      if (!res_valid && res_match) leak++;
      if (sb.size() > 0 && cyc == sb[0].due) begin
        got = sb.pop_front();
        check("res_valid_on_time", int'(res_valid), 1);
        if (res_valid) begin
          check("res_match", int'(res_match), int'(got.match));
          check("fail_cnt_at_result", int'(fail_cnt), got.fcnt);
        end
      end else if (res_valid) begin
        check("res_valid_unexpected", int'(res_valid), 0);
      end
    end
  end

  // ---------------- stimulus tasks (entered at posedge+1) ----------------
  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic do_write(int a, bit [7:0] d);
    check("locked_vs_model", int'(locked), int'(model_locked(cyc)));
    wr_en = 1'b1; wr_addr = ADDR_W'(a); wr_data = d;
    model_write(a, d, cyc);
    step();
    wr_en = 1'b0;
  endtask

  task automatic do_erase(int a);
    clr_en = 1'b1; clr_addr = ADDR_W'(a);
    model_erase(a, cyc);
    step();
    clr_en = 1'b0;
  endtask

  task automatic do_wr_clr(int a, bit [7:0] d);
    wr_en = 1'b1; wr_addr = ADDR_W'(a); wr_data = d;
    clr_en = 1'b1; clr_addr = ADDR_W'(a);
    model_erase(a, cyc);
    model_write(a, d, cyc);
    step();
    wr_en = 1'b0; clr_en = 1'b0;
  endtask

  task automatic do_check(int a, bit [7:0] d, bit with_wr = 1'b0,
                          int wa = 0, bit [7:0] wd = 8'h00);
    int guard = 0;
    while (!model_ready(cyc) && guard < 40) begin
      check("chk_ready_while_busy", int'(chk_ready), 0);
      step();
      guard++;
    end
    check("chk_ready", int'(chk_ready), 1);
    chk_valid = 1'b1; chk_addr = ADDR_W'(a); chk_data = d;
    model_accept(a, d, cyc);
    if (with_wr) begin
      wr_en = 1'b1; wr_addr = ADDR_W'(wa); wr_data = wd;
      model_write(wa, wd, cyc);
    end
    step();
    chk_valid = 1'b0; wr_en = 1'b0;
  endtask

  function automatic bit [7:0] pick_data();
    case ($urandom_range(0, 3))
      0:       return 8'hA5;
      1:       return 8'h3C;
      2:       return 8'h5A;
      default: return 8'($urandom_range(0, 255));
    endcase
  endfunction

  // ---------------- main sequence ----------------
  initial begin
    int lock_seen;
    int guard;
    rst_n = 1'b0;
    wr_en = 1'b0; clr_en = 1'b0; chk_valid = 1'b0;
    wr_addr = '0; clr_addr = '0; chk_addr = '0;
    wr_data = '0; chk_data = '0;
    model_reset();

    repeat (2) @(posedge clk);
    #1;
    check("reset_chk_ready", int'(chk_ready), 0);
    check("reset_res_valid", int'(res_valid), 0);
    check("reset_res_match", int'(res_match), 0);
    check("reset_locked", int'(locked), 0);
    check("reset_fail_cnt", int'(fail_cnt), 0);
    rst_n = 1'b1;
    #1;
    check("chk_ready_after_reset", int'(chk_ready), 1);
    step();

    // Store and match.
    do_write(3, 8'hA5);
    do_check(3, 8'hA5);
    // Never-written entry.
    do_check(5, 8'h00);
    // Clear the count, then three mismatches into lockout.
    do_check(3, 8'hA5);
    do_check(3, 8'h00);
    do_check(3, 8'h01);
    do_check(3, 8'h02);
    lock_seen = 0;
    for (int i = 0; i < LOCK_CYCLES + 2; i++) begin
      step();
      check("lock_locked", int'(locked), int'(model_locked(cyc)));
      check("lock_chk_ready", int'(chk_ready), int'(model_ready(cyc)));
      if (locked) lock_seen++;
      if (i == 4) begin
        wr_en = 1'b1; wr_addr = 4'd3; wr_data = 8'h11;
        model_write(3, 8'h11, cyc);
      end else begin
        wr_en = 1'b0;
      end
    end
    wr_en = 1'b0;
    check("lock_length", lock_seen, LOCK_CYCLES);
    check("fail_cnt_after_lock", int'(fail_cnt), m_fcnt);
    do_check(3, 8'hA5);

    // Write on the acceptance edge: old data wins, new data next time.
    do_check(3, 8'hA5, 1'b1, 3, 8'h3C);
    do_check(3, 8'h3C);
    // Erase, then out-of-range entry (write there is dropped too).
    do_erase(3);
    do_check(3, 8'hA5);
    do_write(15, 8'h77);
    do_check(15, 8'h77);
    // Write and erase of the same entry together: the write holds.
    do_wr_clr(4, 8'h66);
    do_check(4, 8'h66);

    // Random traffic.
    for (int n = 0; n < 250; n++) begin
      int a;
      a = $urandom_range(0, 15);
      case ($urandom_range(0, 5))
        0: do_write(a, pick_data());
        1: do_erase(a);
        2: do_check(a, pick_data());
        3: do_check(a, pick_data(), 1'b1, $urandom_range(0, 15), pick_data());
        4: do_wr_clr(a, pick_data());
        default: step();
      endcase
    end

    // Reset in the middle of a lockout.
    guard = 0;
    while (!model_ready(cyc) && guard < 40) begin step(); guard++; end
    do_write(3, 8'hA5);
    guard = 0;
    while (!(lock_lo > cyc) && guard < 6) begin
      do_check(3, 8'h00);
      guard++;
    end
    repeat (3) step();
    check("pre_reset_locked", int'(locked), int'(model_locked(cyc)));
    rst_n = 1'b0;
    #1;
    check("midlock_reset_locked", int'(locked), 0);
    check("midlock_reset_fail_cnt", int'(fail_cnt), 0);
    check("midlock_reset_chk_ready", int'(chk_ready), 0);
    model_reset();
    sb.delete();
    step();
    rst_n = 1'b1;
    #1;
    check("chk_ready_after_rereset", int'(chk_ready), 1);
    step();
    do_check(3, 8'hA5);

    guard = 0;
    while (sb.size() > 0 && guard < 20) begin step(); guard++; end
    check("scoreboard_drained", sb.size(), 0);
    check("res_match_without_valid", leak, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
